// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the jk_ff command sequencer.
//   - op encodings (the op value is literally the {j,k} pair it drives)
//   - jk_cmd_t: packed command {op, hold} at the default hold width
//   - op_to_jk: op -> {j,k} drive
//   - jk_next:  JK flip-flop next-state rule (used by the readback model)
package jk_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam int JK_HOLD_W = 8;

    typedef struct packed {
        logic [1:0]           op;
        logic [JK_HOLD_W-1:0] hold;
    } jk_cmd_t;

    typedef struct packed {
        logic j;
        logic k;
    } jk_drv_t;

    function automatic jk_drv_t op_to_jk(input logic [1:0] op);
        jk_drv_t d;
        case (op)
            OP_RESET:  d = '{j: 1'b0, k: 1'b1};
            OP_SET:    d = '{j: 1'b1, k: 1'b0};
            OP_TOGGLE: d = '{j: 1'b1, k: 1'b1};
            default:   d = '{j: 1'b0, k: 1'b0};
        endcase
        return d;
    endfunction

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        logic n;
        case ({j, k})
            2'b01:   n = 1'b0;
            2'b10:   n = 1'b1;
            2'b11:   n = ~q;
            default: n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous FIFO holding queued commands.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears pointers/level)
//   push, wdata  write request; ignored while full
//   pop,  rdata  read request; rdata is the current head (first-word fall-through)
//   full, empty  status flags
//   level        occupancy, 0..DEPTH
// DEPTH must be a power of two so pointers wrap by natural overflow.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: command sequencer feeding a jk_ff stage.
// Queues (op, hold) commands and drives each op's j/k pair for hold+1
// cycles, back to back, returning to HOLD (j=k=0) when the queue runs dry.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready = !full)
//   cmd_op, cmd_hold       command payload, sampled only on a push
//   j, k                   registered drive to jk_ff
//   busy                   a command is active
//   done                   1-cycle pulse when the last command finishes with an empty queue
//   fifo_level             queue occupancy
// Optional (macro JK_CMD_SEQ_READBACK_EN):
//   q_fb                   jk_ff.q feedback
//   mismatch               1-cycle pulse when q_fb disagrees with the model
//   mismatch_cnt           saturating mismatch count
module jk_cmd_seq
    import jk_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = JK_HOLD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [HOLD_W-1:0]       cmd_hold,
    output logic                    j,
    output logic                    k,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  fifo_level
`ifdef JK_CMD_SEQ_READBACK_EN
    ,
    input  logic                    q_fb,
    output logic                    mismatch,
    output logic [7:0]              mismatch_cnt
`endif
);

    localparam int CW = HOLD_W + 2;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]        state;
    logic [HOLD_W-1:0] remaining;
    logic [CW-1:0]     head;
    logic [1:0]        head_op;
    logic [HOLD_W-1:0] head_hold;
    jk_drv_t           head_drv;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              cur_last;

    assign cmd_ready = ~fifo_full;
    assign head_op   = head[CW-1 -: 2];
    assign head_hold = head[HOLD_W-1:0];
    assign head_drv  = op_to_jk(head_op);
    assign busy      = (state == S_ACTIVE);

    // Current command is in its final cycle (idle counts as "finished"),
    // so the head can be loaded at this edge with no HOLD gap.
    assign cur_last  = (state == S_IDLE) || (remaining == '0);
    assign fifo_pop  = cur_last & ~fifo_empty;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata ({cmd_op, cmd_hold}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fifo_pop) begin
                state     <= S_ACTIVE;
                j         <= head_drv.j;
                k         <= head_drv.k;
                remaining <= head_hold;
            end else if (state == S_ACTIVE) begin
                if (remaining != '0) begin
                    remaining <= remaining - 1'b1;
                end else begin
                    state <= S_IDLE;
                    j     <= 1'b0;
                    k     <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

`ifdef JK_CMD_SEQ_READBACK_EN
    // jk_ff powers up unknown, so q_exp is only trusted once a SET or
    // RESET (j != k) has actually been applied to it.
    logic q_exp;
    logic synced;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_exp        <= 1'b0;
            synced       <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            q_exp    <= jk_next(j, k, q_exp);
            synced   <= synced | (j ^ k);
            mismatch <= 1'b0;
            if (synced && (q_fb != q_exp)) begin
                mismatch <= 1'b1;
                if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
module tb_jk_cmd_seq;
    import jk_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_hold;
    logic       j, k, busy, done;
    logic [2:0] fifo_level;
`ifdef JK_CMD_SEQ_READBACK_EN
    logic       q_fb, mismatch, q_model, force_en;
    logic [7:0] mismatch_cnt;
`endif

    always #5 clk = ~clk;

    jk_cmd_seq #(.DEPTH(4), .HOLD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_hold   (cmd_hold),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level)
`ifdef JK_CMD_SEQ_READBACK_EN
        ,
        .q_fb         (q_fb),
        .mismatch     (mismatch),
        .mismatch_cnt (mismatch_cnt)
`endif
    );

`ifdef JK_CMD_SEQ_READBACK_EN
    // Behavioural jk_ff attached to the outputs; force_en pins q_fb low
    // whenever a TOGGLE is being driven.
    initial q_model = 1'b0;
    always @(posedge clk) q_model <= jk_next(j, k, q_model);
    assign q_fb = (force_en && busy && j && k) ? 1'b0 : q_model;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        jk_cmd_t    cmd;
        logic [1:0] jk;
        logic       busy;
        logic       done;
        logic [2:0] level;
        logic       ready;
    } vec_t;

    typedef struct {
        logic [1:0] jk;
        int         len;
    } seg_t;

    vec_t vecs[14];
    seg_t seg_q[$];
    seg_t exp_q[$];
    logic mon_en = 1'b0;
    logic [1:0] cur_jk;
    int   cur_len = 0;

    // Run-length encode the drive while busy; consecutive commands in a
    // session always use different ops so segment boundaries are visible.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (cur_len > 0 && {j, k} == cur_jk) begin
                    cur_len = cur_len + 1;
                end else begin
                    if (cur_len > 0) seg_q.push_back('{jk: cur_jk, len: cur_len});
                    cur_jk  = {j, k};
                    cur_len = 1;
                end
            end else if (cur_len > 0) begin
                seg_q.push_back('{jk: cur_jk, len: cur_len});
                cur_len = 0;
            end
        end
    end

    function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [7:0] h,
                                input logic [1:0] ejk, input logic eb, input logic ed,
                                input logic [2:0] el, input logic er);
        vec_t r;
        r.valid = v; r.cmd.op = op; r.cmd.hold = h;
        r.jk = ejk; r.busy = eb; r.done = ed; r.level = el; r.ready = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] h);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_hold = h;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back('{jk: op, len: int'(h) + 1});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || fifo_level != 0) && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) chk({tag, "_drain_timeout"}, 32'(n), 32'd0);
        tick();
    endtask

    task automatic check_segs(input string tag);
        chk({tag, "_seg_count"}, 32'(seg_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seg_q.size(); i++) begin
            chk($sformatf("%s_seg%0d_jk", tag, i), 32'(seg_q[i].jk), 32'(exp_q[i].jk));
            chk($sformatf("%s_seg%0d_len", tag, i), 32'(seg_q[i].len), 32'(exp_q[i].len));
        end
    endtask

    task automatic start_session();
        mon_en  = 1'b0;
        cur_len = 0;
        seg_q.delete();
        exp_q.delete();
        mon_en  = 1'b1;
    endtask

    initial begin
        // single TOGGLE h=3, then back-to-back SET h0 / RESET h1 / HOLD h0
        vecs[0]  = mk(1, OP_TOGGLE, 3, 2'b00, 0, 0, 1, 1);
        vecs[1]  = mk(0, OP_HOLD,   0, 2'b11, 1, 0, 0, 1);
        vecs[2]  = mk(0, OP_HOLD,   0, 2'b11, 1, 0, 0, 1);
        vecs[3]  = mk(0, OP_HOLD,   0, 2'b11, 1, 0, 0, 1);
        vecs[4]  = mk(0, OP_HOLD,   0, 2'b11, 1, 0, 0, 1);
        vecs[5]  = mk(0, OP_HOLD,   0, 2'b00, 0, 1, 0, 1);
        vecs[6]  = mk(0, OP_HOLD,   0, 2'b00, 0, 0, 0, 1);
        vecs[7]  = mk(1, OP_SET,    0, 2'b00, 0, 0, 1, 1);
        vecs[8]  = mk(1, OP_RESET,  1, 2'b10, 1, 0, 1, 1);
        vecs[9]  = mk(1, OP_HOLD,   0, 2'b01, 1, 0, 1, 1);
        vecs[10] = mk(0, OP_HOLD,   0, 2'b01, 1, 0, 1, 1);
        vecs[11] = mk(0, OP_HOLD,   0, 2'b00, 1, 0, 0, 1);
        vecs[12] = mk(0, OP_HOLD,   0, 2'b00, 0, 1, 0, 1);
        vecs[13] = mk(0, OP_HOLD,   0, 2'b00, 0, 0, 0, 1);

`ifdef JK_CMD_SEQ_READBACK_EN
        force_en = 1'b0;
`endif
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_hold = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_jk",    {30'd0, j, k}, 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            cmd_valid = vecs[i].valid;
            cmd_op    = vecs[i].cmd.op;
            cmd_hold  = vecs[i].cmd.hold;
            tick();
            chk($sformatf("row%0d_jk", i),    32'({j, k}),      32'(vecs[i].jk));
            chk($sformatf("row%0d_busy", i),  32'(busy),        32'(vecs[i].busy));
            chk($sformatf("row%0d_done", i),  32'(done),        32'(vecs[i].done));
            chk($sformatf("row%0d_level", i), 32'(fifo_level),  32'(vecs[i].level));
            chk($sformatf("row%0d_ready", i), 32'(cmd_ready),   32'(vecs[i].ready));
        end
        cmd_valid = 1'b0;

        // reset with a long command active and 3 queued
        push_cmd(OP_TOGGLE, 200);
        push_cmd(OP_SET, 5);
        push_cmd(OP_RESET, 5);
        push_cmd(OP_SET, 5);
        chk("midrst_pre_level", 32'(fifo_level), 32'd3);
        chk("midrst_pre_busy",  32'(busy), 32'd1);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("midrst%0d_jk", c),    32'({j, k}), 32'd0);
            chk($sformatf("midrst%0d_busy", c),  32'(busy), 32'd0);
            chk($sformatf("midrst%0d_done", c),  32'(done), 32'd0);
            chk($sformatf("midrst%0d_level", c), 32'(fifo_level), 32'd0);
            chk($sformatf("midrst%0d_ready", c), 32'(cmd_ready), 32'd1);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("postrst%0d_done", c), 32'(done), 32'd0);
            chk($sformatf("postrst%0d_busy", c), 32'(busy), 32'd0);
        end

        // full: long SET then 4 queued, 5th held off until a pop
        start_session();
        push_cmd(OP_SET, 20);
        push_cmd(OP_TOGGLE, 1);
        push_cmd(OP_HOLD, 2);
        push_cmd(OP_RESET, 0);
        push_cmd(OP_SET, 3);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_op = OP_TOGGLE; cmd_hold = 8'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("full_hold%0d_level", c), 32'(fifo_level), 32'd4);
            chk($sformatf("full_hold%0d_ready", c), 32'(cmd_ready), 32'd0);
        end
        begin
            int n = 0;
            while (!cmd_ready && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) chk("full_wait_timeout", 32'(n), 32'd0);
        end
        // the pop that freed a slot must not have taken the held command
        chk("full_after_pop_level", 32'(fifo_level), 32'd3);
        tick();
        cmd_valid = 1'b0;
        chk("full_after_push_level", 32'(fifo_level), 32'd4);
        exp_q.push_back('{jk: OP_TOGGLE, len: 2});
        wait_idle("full");
        check_segs("full");

        // stream of 10 with random gaps; pointers wrap several times
        start_session();
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            push_cmd(2'(i % 4), 8'($urandom_range(0, 3)));
        end
        wait_idle("wrap");
        check_segs("wrap");
        mon_en = 1'b0;

`ifdef JK_CMD_SEQ_READBACK_EN
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            force_en = (pass == 1);
            push_cmd(OP_SET, 0);
            push_cmd(OP_TOGGLE, 5);
            wait_idle("rb");
            tick();
            chk($sformatf("rb%0d_mismatch_cnt", pass), 32'(mismatch_cnt),
                (pass == 1) ? 32'd3 : 32'd0);
            force_en = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_cmd_seq.md
Name: jk_cmd_seq

Overview:
Command sequencer directly upstream of the jk_ff stage; drives its j/k inputs.
- Accepts (op, hold) commands over a valid/ready interface and buffers them in a small FIFO.
- Applies each command's j/k pair for hold+1 clock cycles; between commands it drives HOLD (j=0, k=0).
- Lets benches and the top level script flip-flop activity without hand-timed stimulus.

Parameters:
DEPTH, 4, command FIFO entries; power of two, 2..16.
HOLD_W, 8, width of the hold-count field; a command lasts 1..2^HOLD_W cycles.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO can accept; equals !full.
cmd_op  in  2  00 HOLD (j0 k0), 01 RESET (j0 k1), 10 SET (j1 k0), 11 TOGGLE (j1 k1).
cmd_hold  in  HOLD_W  command applied for cmd_hold+1 cycles.
j  out  1  registered drive to jk_ff.j.
k  out  1  registered drive to jk_ff.k.
busy  out  1  high while a command is active.
done  out  1  one-cycle pulse after the last cycle of a command when the FIFO is then empty.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: when rst=1 at an edge:
  - FIFO cleared, fifo_level=0.
  - j=0, k=0, busy=0, done=0.
  - cmd_ready=1 after the edge.
  - Reset mid-command aborts it immediately; no done pulse is issued.
- Push: occurs when cmd_valid & cmd_ready at an edge.
  - cmd_ready=0 when full, even if a pop happens in the same cycle (no push-through-full).
- FSM has two states, IDLE and ACTIVE.
- IDLE (busy=0, j=k=0):
  - If the FIFO is non-empty at an edge: pop the head, load j/k from op, load remaining=hold, go to ACTIVE.
  - Latency: command pushed at edge t into an empty FIFO; j/k reflect it after edge t+1.
- ACTIVE (busy=1):
  - Each edge with remaining>0: decrement remaining.
  - At an edge with remaining==0, FIFO non-empty: pop the next command and load it. No HOLD gap between back-to-back commands.
  - At an edge with remaining==0, FIFO empty: j=k=0, go to IDLE, done=1 for exactly one cycle.
- Simultaneous push and pop: allowed when not full; fifo_level is unchanged.
- FIFO pointers wrap modulo DEPTH.
- hold at maximum: the command lasts 2^HOLD_W cycles; remaining never underflows.
- cmd_op/cmd_hold are sampled only on a push; they are don't-care otherwise.

Optional Feature:
Macro JK_CMD_SEQ_READBACK_EN.
- Defined:
  - Extra ports: q_fb in 1 (from jk_ff.q); mismatch out 1; mismatch_cnt out 8.
  - Internal model q_exp is updated each edge from the registered j/k using JK rules.
  - jk_ff has no reset, so checking is enabled only after the first SET or RESET has been applied ("synced" flag).
  - When synced and q_fb != q_exp: mismatch pulses for one cycle; mismatch_cnt increments, saturating at 255.
  - rst clears synced, q_exp, and the counter.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package jk_pkg:
  - op encoding localparams OP_HOLD/OP_RESET/OP_SET/OP_TOGGLE.
  - typedef of the packed command {op, hold}.
  - function op_to_jk.
- One sub-module jk_cmd_fifo: synchronous FIFO with sync rst, DEPTH parameter, level output, and push/pop/full/empty.
- FSM and readback checker stay in jk_cmd_seq.

Test Plan:
- Reset: assert rst for 2 cycles while FIFO holds 3 commands -> j=k=0, busy=0, fifo_level=0, cmd_ready=1, no done.
- Single command: push TOGGLE hold=3 into idle block at edge t -> j=k=1 from edge t+1 through t+4; j=k=0 and done=1 after edge t+5.
- Back-to-back: push SET h=0, RESET h=1, HOLD h=0 -> j/k sequence 10, 01, 01, 00 on consecutive cycles, no gaps; exactly one done pulse.
- Full: with DEPTH=4 and an active long command, push 4 commands -> cmd_ready=0; 5th valid held and not accepted until a pop; no entry lost or duplicated.
- Wrap: stream 10 commands with random valid gaps -> output order matches push order across pointer wrap.
- JK_CMD_SEQ_READBACK_EN defined:
  - Correct jk_ff attached: after SET then TOGGLE h=5 -> mismatch_cnt=0.
  - q_fb forced to 0 during the TOGGLE -> mismatch_cnt=3.
